rrot_sched_8: RTL and testbench



---
 rtl/rrot_sched_8.sv | 116 +++++++++++
 tb/tb_rrot_sched_8.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rrot_sched_8.sv
// Two-requester scheduler sharing one combinational 8-bit right rotator.
// Define RROT_SCHED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module rrot_sched_8 #(
   parameter int unsigned   W        = 8,
   parameter logic [W-1:0]  RST_DATA = 8'h00
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_data,
   input  logic [2:0]   req0_amt,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_data,
   input  logic [2:0]   req1_amt,
   output logic [W-1:0] rot_data,
   output logic [2:0]   rot_sel,
   input  logic [W-1:0] rot_out,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         rsp_id,
   output logic         busy
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e       state_q, state_d;
   logic [W-1:0] rot_data_q, rot_data_d;
   logic [2:0]   rot_sel_q, rot_sel_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic [W-1:0] rsp_data_q, rsp_data_d;
   logic         rsp_id_q, rsp_id_d;
   logic         last_gnt_q, last_gnt_d;
   logic         gnt0, gnt1;

`ifdef RROT_SCHED_PRIO_EN
   assign gnt0 = req0_valid;
   assign gnt1 = req1_valid & ~req0_valid;
`else
   // On a tie, the requester that did not win last time goes next.
   assign gnt0 = req0_valid & (~req1_valid | last_gnt_q);
   assign gnt1 = req1_valid & (~req0_valid | ~last_gnt_q);
`endif

   assign req0_ready = (state_q == StIdle) & gnt0 & ~rst;
   assign req1_ready = (state_q == StIdle) & gnt1 & ~rst;

   always_comb begin
      state_d     = state_q;
      rot_data_d  = rot_data_q;
      rot_sel_d   = rot_sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      last_gnt_d  = last_gnt_q;
      unique case (state_q)
         StIdle: begin
            if (req0_ready) begin
               rot_data_d = req0_data;
               rot_sel_d  = req0_amt;
               rsp_id_d   = 1'b0;
               last_gnt_d = 1'b0;
               state_d    = StIssue;
            end else if (req1_ready) begin
               rot_data_d = req1_data;
               rot_sel_d  = req1_amt;
               rsp_id_d   = 1'b1;
               last_gnt_d = 1'b1;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            rsp_data_d  = rot_out;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rot_data_q  <= RST_DATA;
         rot_sel_q   <= 3'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= RST_DATA;
         rsp_id_q    <= 1'b0;
         last_gnt_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         rot_data_q  <= rot_data_d;
         rot_sel_q   <= rot_sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         last_gnt_q  <= last_gnt_d;
      end
   end

   assign rot_data  = rot_data_q;
   assign rot_sel   = rot_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_rrot_sched_8.sv
// Directed, table-driven bench for rrot_sched_8 with a behavioural right rotator attached.
module tb_rrot_sched_8;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0] req0_data, req1_data;
   logic [2:0] req0_amt, req1_amt;
   logic [7:0] rot_data, rot_out, rsp_data;
   logic [2:0] rot_sel;
   logic       rsp_valid, rsp_ready, rsp_id, busy;
   logic [15:0] rot_dbl;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] data;
      logic [2:0] amt;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl [8];

   always #5 clk = ~clk;

   // Behavioural rrot_8: out = data rotated right by sel.
   assign rot_dbl = {rot_data, rot_data} >> rot_sel;
   assign rot_out = rot_dbl[7:0];

   rrot_sched_8 dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_data  (req0_data),
      .req0_amt   (req0_amt),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_data  (req1_data),
      .req1_amt   (req1_amt),
      .rot_data   (rot_data),
      .rot_sel    (rot_sel),
      .rot_out    (rot_out),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .busy       (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b", nm, got, exp);
      end
   endtask

   function automatic logic cond(input int which);
      return (which == 0) ? rsp_valid : (req0_ready | req1_ready);
   endfunction

   // which=0: rsp_valid, which=1: either ready. Bounded wait, failure counted.
   task automatic wait_cond(input int which, input string nm);
      int n = 0;
      while (!cond(which) && n < 8) begin
         tick();
         n++;
      end
      chkb(nm, cond(which), 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic op0(input logic [7:0] d, input logic [2:0] a, input logic [7:0] e);
      req0_valid = 1'b1;
      req0_data  = d;
      req0_amt   = a;
      rsp_ready  = 1'b1;
      #1;
      wait_cond(1, "tbl_rdy");
      tick();
      req0_valid = 1'b0;
      wait_cond(0, "tbl_vld");
      chk("tbl_data", rsp_data, e);
      chkb("tbl_id", rsp_id, 1'b0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nops;
      int hi;
      logic exp_id;

      tbl[0] = '{8'hA5, 3'd0, 8'hA5};
      tbl[1] = '{8'hA5, 3'd1, 8'hD2};
      tbl[2] = '{8'hA5, 3'd2, 8'h69};
      tbl[3] = '{8'hA5, 3'd3, 8'hB4};
      tbl[4] = '{8'hA5, 3'd4, 8'h5A};
      tbl[5] = '{8'hA5, 3'd5, 8'h2D};
      tbl[6] = '{8'hA5, 3'd6, 8'h96};
      tbl[7] = '{8'hA5, 3'd7, 8'h4B};

      req0_valid = 1'b1;
      req1_valid = 1'b0;
      req0_data  = 8'h00;
      req1_data  = 8'h00;
      req0_amt   = 3'd0;
      req1_amt   = 3'd0;
      rsp_ready  = 1'b0;
      rst        = 1'b1;
      tick();
      tick();
      // Still in reset: ready must stay low despite a valid request.
      chkb("rst_req0_ready", req0_ready, 1'b0);
      chkb("rst_req1_ready", req1_ready, 1'b0);
      chk("rst_rot_data", rot_data, 8'h00);
      chk("rst_rot_sel", 8'(rot_sel), 8'h00);
      chkb("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, 8'h00);
      chkb("rst_rsp_id", rsp_id, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      req0_valid = 1'b0;
      rst        = 1'b0;
      tick();

      // Single op latency: ready seen, handshake next edge, rsp_valid one edge after that.
      req0_valid = 1'b1;
      req0_data  = 8'b10100101;
      req0_amt   = 3'd1;
      rsp_ready  = 1'b1;
      #1;
      chkb("lat_ready", req0_ready, 1'b1);
      tick();
      req0_valid = 1'b0;
      chkb("lat_ready_pulse", req0_ready, 1'b0);
      chkb("lat_vld_early", rsp_valid, 1'b0);
      chkb("lat_busy", busy, 1'b1);
      chk("lat_rot_data", rot_data, 8'b10100101);
      chk("lat_rot_sel", 8'(rot_sel), 8'd1);
      tick();
      chkb("lat_vld", rsp_valid, 1'b1);
      chk("lat_data", rsp_data, 8'b11010010);
      chkb("lat_id", rsp_id, 1'b0);
      tick();
      chkb("lat_vld_drop", rsp_valid, 1'b0);
      chkb("lat_idle", busy, 1'b0);

      foreach (tbl[i]) op0(tbl[i].data, tbl[i].amt, tbl[i].exp);

      // Both requesters valid every cycle.
      do_reset();
      req0_valid = 1'b1;
      req0_data  = 8'hA5;
      req0_amt   = 3'd3;
      req1_valid = 1'b1;
      req1_data  = 8'h81;
      req1_amt   = 3'd4;
      rsp_ready  = 1'b1;
      #1;
`ifdef RROT_SCHED_PRIO_EN
      nops = 10;
`else
      nops = 8;
`endif
      for (int i = 0; i < nops; i++) begin
`ifdef RROT_SCHED_PRIO_EN
         exp_id = 1'b0;
`else
         exp_id = (i % 2) == 1;
`endif
         wait_cond(1, "alt_rdy");
         chkb("alt_req0_ready", req0_ready, ~exp_id);
         chkb("alt_req1_ready", req1_ready, exp_id);
         tick();
         wait_cond(0, "alt_vld");
         chk("alt_data", rsp_data, exp_id ? 8'h18 : 8'b10110100);
         chkb("alt_id", rsp_id, exp_id);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      // Backpressure in RESP, then a new request pending when the response completes.
      req0_valid = 1'b1;
      req0_data  = 8'hA5;
      req0_amt   = 3'd3;
      rsp_ready  = 1'b0;
      #1;
      wait_cond(1, "bp_rdy");
      tick();
      req0_valid = 1'b0;
      tick();
      req1_valid = 1'b1;
      req1_data  = 8'h81;
      req1_amt   = 3'd4;
      for (int i = 0; i < 5; i++) begin
         chkb("bp_vld", rsp_valid, 1'b1);
         chk("bp_data", rsp_data, 8'hB4);
         chkb("bp_id", rsp_id, 1'b0);
         chkb("bp_no_ready", req0_ready | req1_ready, 1'b0);
         chkb("bp_busy", busy, 1'b1);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chkb("bp_release_vld", rsp_valid, 1'b0);
      chkb("bp_release_busy", busy, 1'b0);
      chkb("bp_next_grant", req1_ready, 1'b1);
      tick();
      req1_valid = 1'b0;
      wait_cond(0, "bp_next_vld");
      chk("bp_next_data", rsp_data, 8'h18);
      chkb("bp_next_id", rsp_id, 1'b1);
      tick();

      // Reset during ISSUE drops the op and restores last_gnt.
      req0_valid = 1'b1;
      req0_data  = 8'h55;
      req0_amt   = 3'd2;
      #1;
      wait_cond(1, "mid_rdy");
      tick();
      req0_valid = 1'b0;
      chk("mid_rot_data", rot_data, 8'h55);
      chk("mid_rot_sel", 8'(rot_sel), 8'd2);
      chkb("mid_busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      chkb("mid_rst_vld", rsp_valid, 1'b0);
      chk("mid_rst_rot_data", rot_data, 8'h00);
      chk("mid_rst_rot_sel", 8'(rot_sel), 8'd0);
      chk("mid_rst_rsp_data", rsp_data, 8'h00);
      chkb("mid_rst_busy", busy, 1'b0);
      rst = 1'b0;
      hi  = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid) hi++;
      end
      chk("mid_no_rsp", 8'(hi), 8'd0);
      req0_valid = 1'b1;
      req0_data  = 8'h01;
      req0_amt   = 3'd1;
      req1_valid = 1'b1;
      req1_data  = 8'h81;
      req1_amt   = 3'd4;
      #1;
      chkb("mid_tie_req0", req0_ready, 1'b1);
      chkb("mid_tie_req1", req1_ready, 1'b0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_cond(0, "mid_vld");
      chk("mid_data", rsp_data, 8'h80);
      chkb("mid_id", rsp_id, 1'b0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
